// File: rtl/clkdiv_pkg.sv
// Shared defaults and mode encoding for the programmable clock divider.
package clkdiv_pkg;

  localparam int unsigned CNT_W_DEF = 32;
  localparam int unsigned N_CH_DEF  = 4;
  localparam int unsigned DIV_W_DEF = 16;

  typedef enum logic {
    MODE_PULSE = 1'b0,
    MODE_SQ    = 1'b1
  } mode_e;

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: active/shadow config, period counter, tick and square outputs.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             we,
  input  logic [DIV_W-1:0] wdiv,
  input  logic             wmode,
  output logic             tick,
  output logic             sq,
  output logic             pend
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] sdiv_q;
  logic [DIV_W-1:0] cnt_q;
  mode_e            mode_q;
  mode_e            smode_q;

  logic             tc_c;
  logic [DIV_W-1:0] nxt_div_c;
  mode_e            nxt_mode_c;
  logic             sq_apply_c;

  assign tc_c = en && (div_q != '0) && (cnt_q == div_q - DIV_W'(1));

  // A write landing on the TC edge overrides whatever sits in the shadow.
  assign nxt_div_c  = we ? wdiv : sdiv_q;
  assign nxt_mode_c = we ? mode_e'(wmode) : smode_q;

  // Square phase survives an apply only if the channel stays in square mode.
  assign sq_apply_c = (nxt_div_c != '0) && (nxt_mode_c == MODE_SQ) &&
                      (mode_q == MODE_SQ) && !sq;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      sdiv_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_PULSE;
      smode_q <= MODE_PULSE;
      tick    <= 1'b0;
      sq      <= 1'b0;
      pend    <= 1'b0;
    end else begin
      tick <= tc_c;
      if (we) begin
        sdiv_q  <= wdiv;
        smode_q <= mode_e'(wmode);
      end
      if (div_q == '0) begin
        cnt_q <= '0;
        sq    <= 1'b0;
        pend  <= 1'b0;
        if (we) begin
          div_q  <= wdiv;
          mode_q <= mode_e'(wmode);
        end
      end else if (tc_c) begin
        cnt_q <= '0;
        pend  <= 1'b0;
        if (we || pend) begin
          div_q  <= nxt_div_c;
          mode_q <= nxt_mode_c;
          sq     <= sq_apply_c;
        end else begin
          sq <= (mode_q == MODE_SQ) ? !sq : 1'b0;
        end
      end else begin
        if (en) cnt_q <= cnt_q + DIV_W'(1);
        if (we) pend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clkdiv_prog.sv
// Free-running counter plus N_CH programmable divider channels with shadowed config.
module clkdiv_prog
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned N_CH  = N_CH_DEF,
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic                                 cfg_we,
  input  logic [$clog2(N_CH > 1 ? N_CH : 2)-1:0] cfg_ch,
  input  logic [DIV_W-1:0]                     cfg_div,
  input  logic                                 cfg_mode,
  output logic [CNT_W-1:0]                     clkdiv,
  output logic [N_CH-1:0]                      tick,
  output logic [N_CH-1:0]                      sq,
  output logic [N_CH-1:0]                      cfg_pend
);

  localparam int unsigned CH_W = $clog2(N_CH > 1 ? N_CH : 2);

  always_ff @(posedge clk) begin
    if (rst)     clkdiv <= '0;
    else if (en) clkdiv <= clkdiv + CNT_W'(1);
  end

  // Out-of-range channel numbers match no instance and are dropped.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic we_c;
    assign we_c = cfg_we && (cfg_ch == CH_W'(i));

    clkdiv_chan #(
      .DIV_W(DIV_W)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .we   (we_c),
      .wdiv (cfg_div),
      .wmode(cfg_mode),
      .tick (tick[i]),
      .sq   (sq[i]),
      .pend (cfg_pend[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_prog.sv
// Directed scoreboard bench for clkdiv_prog (CNT_W=8, N_CH=6, DIV_W=8).
module tb_clkdiv_prog;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned N_CH  = 6;
  localparam int unsigned DIV_W = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic             cfg_we;
  logic [2:0]       cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_mode;
  logic [CNT_W-1:0] clkdiv;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  sq;
  logic [N_CH-1:0]  cfg_pend;

  clkdiv_prog #(
    .CNT_W(CNT_W),
    .N_CH (N_CH),
    .DIV_W(DIV_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .cfg_mode(cfg_mode),
    .clkdiv  (clkdiv),
    .tick    (tick),
    .sq      (sq),
    .cfg_pend(cfg_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // fld: 0 clkdiv, 1 tick bit, 2 sq bit, 3 pend bit, 4 tick vec, 5 sq vec, 6 pend vec
  typedef struct {
    string name;
    int    fld;
    int    idx;
    int    exp;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input int fld, input int idx, input int exp);
    exp_t e;
    e.name = name; e.fld = fld; e.idx = idx; e.exp = exp;
    q.push_back(e);
  endtask

  // Monitor: drains expectations at the falling edge, away from the active edge.
  always @(negedge clk) begin
    while (q.size() != 0) begin
      exp_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.fld)
        0:       act = 32'(clkdiv);
        1:       act = 32'(tick[e.idx]);
        2:       act = 32'(sq[e.idx]);
        3:       act = 32'(cfg_pend[e.idx]);
        4:       act = 32'(tick);
        5:       act = 32'(sq);
        default: act = 32'(cfg_pend);
      endcase
      n_tests++;
      if (act !== 32'(e.exp)) begin
        n_fail++;
        $display("FAIL %s[%0d] @%0t: got %0d expected %0d", e.name, e.idx, $time, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int d, input logic m);
    cfg_we   = 1'b1;
    cfg_ch   = 3'(ch);
    cfg_div  = DIV_W'(d);
    cfg_mode = m;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    cfg_we = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
    step();
    chk("rst_clkdiv", 0, 0, 0);
    chk("rst_tick", 4, 0, 0);
    chk("rst_sq", 5, 0, 0);
    chk("rst_pend", 6, 0, 0);

    // Free-running counter and wrap
    rst = 1'b0; en = 1'b1;
    repeat (20) step();
    chk("clkdiv_20", 0, 0, 20);
    repeat (235) step();
    chk("clkdiv_255", 0, 0, 255);
    step();
    chk("clkdiv_wrap", 0, 0, 0);

    // ch0 div=4 pulse, then div=1
    do_reset();
    wr(0, 4, 1'b0);
    step();
    cfg_we = 1'b0;
    chk("ch0_apply_pend", 3, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("ch0_div4_tick", 1, 0, (k % 4 == 0) ? 1 : 0);
    end
    wr(0, 1, 1'b0);
    step();
    cfg_we = 1'b0;
    chk("ch0_div1_pend", 3, 0, 1);
    chk("ch0_div1_tick", 1, 0, 0);
    repeat (2) begin
      step();
      chk("ch0_div1_pend_hold", 3, 0, 1);
    end
    step();
    chk("ch0_div1_apply_tick", 1, 0, 1);
    chk("ch0_div1_apply_pend", 3, 0, 0);
    repeat (4) begin
      step();
      chk("ch0_div1_tick_const", 1, 0, 1);
    end
    chk("ch0_pulse_sq", 2, 0, 0);

    // ch1 div=3 square, pause mid-period
    wr(1, 3, 1'b1);
    step();
    cfg_we = 1'b0;
    chk("ch1_apply_sq", 2, 1, 0);
    chk("ch1_apply_pend", 3, 1, 0);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("ch1_sq", 2, 1, ((k >= 3 && k <= 5) || k >= 9) ? 1 : 0);
      chk("ch1_tick", 1, 1, (k % 3 == 0) ? 1 : 0);
    end
    en = 1'b0;
    repeat (5) begin
      step();
      chk("ch1_pause_sq", 2, 1, 1);
      chk("ch1_pause_tick", 1, 1, 0);
      chk("ch0_pause_tick", 1, 0, 0);
    end
    en = 1'b1;
    step();
    chk("ch1_resume_sq", 2, 1, 1);
    chk("ch1_resume_tick", 1, 1, 0);
    step();
    chk("ch1_resume_tc_sq", 2, 1, 0);
    chk("ch1_resume_tc_tick", 1, 1, 1);

    // ch3 div=5, retarget mid-period to 2, then write on TC
    do_reset();
    wr(3, 5, 1'b0);
    step();
    for (int k = 1; k <= 14; k++) begin
      cfg_we = 1'b0;
      if (k == 2)  wr(3, 2, 1'b0);
      if (k == 11) wr(3, 3, 1'b0);
      step();
      chk("ch3_pend", 3, 3, (k >= 2 && k <= 4) ? 1 : 0);
      chk("ch3_tick", 1, 3, (k == 5 || k == 7 || k == 9 || k == 11 || k == 14) ? 1 : 0);
    end
    cfg_we = 1'b0;

    // ch2 square: 4 -> 6 -> 8 (last wins), later disable with div=0
    do_reset();
    wr(2, 4, 1'b1);
    step();
    for (int k = 1; k <= 32; k++) begin
      cfg_we = 1'b0;
      if (k == 1)  wr(2, 6, 1'b1);
      if (k == 2)  wr(2, 8, 1'b1);
      if (k == 21) wr(2, 0, 1'b1);
      step();
      chk("ch2_tick", 1, 2, (k == 4 || k == 12 || k == 20 || k == 28) ? 1 : 0);
      chk("ch2_sq", 2, 2, ((k >= 4 && k < 12) || (k >= 20 && k < 28)) ? 1 : 0);
      chk("ch2_pend", 3, 2, ((k >= 1 && k < 4) || (k >= 21 && k < 28)) ? 1 : 0);
    end
    cfg_we = 1'b0;

    // Out-of-range channel numbers are ignored
    wr(7, 5, 1'b1);
    step();
    cfg_we = 1'b0;
    chk("oor7_pend", 6, 0, 0);
    wr(6, 3, 1'b0);
    step();
    cfg_we = 1'b0;
    chk("oor6_pend", 6, 0, 0);
    repeat (6) begin
      step();
      chk("oor_tick", 4, 0, 0);
      chk("oor_sq", 5, 0, 0);
    end

    // Reset mid-period with a write pending and a write in flight
    do_reset();
    wr(0, 4, 1'b1);
    step();
    cfg_we = 1'b0;
    repeat (5) step();
    chk("pre_rst_sq", 2, 0, 1);
    wr(0, 7, 1'b1);
    step();
    chk("pre_rst_pend", 3, 0, 1);
    rst = 1'b1;
    wr(0, 3, 1'b0);
    step();
    rst = 1'b0;
    cfg_we = 1'b0;
    chk("rst2_clkdiv", 0, 0, 0);
    chk("rst2_tick", 4, 0, 0);
    chk("rst2_sq", 5, 0, 0);
    chk("rst2_pend", 6, 0, 0);
    repeat (10) begin
      step();
      chk("post_rst_tick", 4, 0, 0);
      chk("post_rst_sq", 5, 0, 0);
      chk("post_rst_pend", 6, 0, 0);
    end
    chk("post_rst_clkdiv", 0, 0, 10);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
